mul_add_row: RTL and testbench
==============================

Name: mul_add_row

Overview:
- Word-serial multi-precision multiply-accumulate engine: computes {carry_out, S} = A*b + Z + cin.
- A and Z are NUM_WORDS-word operands streamed least-significant word first; b and cin are single words latched at start.
- It is the row primitive of the RSA Montgomery datapath; the controller issues one row per outer-loop iteration and consumes S words plus the final carry.
- It adds to the combinational word multiply-add: a carry chain across words, valid/ready streaming with backpressure, and start/done sequencing.

Parameters:
- DATA_WIDTH, 32, word width in bits (shared value from parameter.v)
- NUM_WORDS, 32, words per operand row (>=1)
- CNT_WIDTH, $clog2(NUM_WORDS+1), word counter width (derived, do not override)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse, begins a row; sampled only in IDLE
- b  in  DATA_WIDTH  row multiplier word, latched on accepted start
- cin  in  DATA_WIDTH  initial carry word, latched on accepted start
- busy  out  1  high from accepted start until done
- in_valid  in  1  a_word/z_word valid
- in_ready  out  1  engine accepts a word pair this cycle
- a_word  in  DATA_WIDTH  current A word
- z_word  in  DATA_WIDTH  current Z word
- out_valid  out  1  s_word valid
- out_ready  in  1  downstream accepts s_word
- s_word  out  DATA_WIDTH  result word
- out_last  out  1  qualifies the final s_word of the row
- carry_out  out  DATA_WIDTH  final carry word; valid from done until next accepted start
- done  out  1  single-cycle pulse, row complete

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; busy, in_ready, out_valid, out_last, done = 0; s_word, carry_out, internal carry, b register and counter = 0. Asserting reset mid-row aborts the row with no partial outputs.
- Per word, with carry register c: {c_next, s} = a_word*b + z_word + c, computed at 2*DATA_WIDTH bits. The maximum value is (2^W-1)^2 + 2(2^W-1) = 2^(2W)-1, so it never overflows; c_next is exactly DATA_WIDTH bits.
- IDLE: a start pulse latches b, cin->c and clears the counter; the next state is RUN and busy rises the following cycle. While busy, start is ignored.
- RUN: in_ready = (cnt < NUM_WORDS) && (!out_valid || out_ready).
  - On an in_valid && in_ready transfer: s_word, out_valid=1 and c are registered, cnt increments, and out_last = (cnt == NUM_WORDS-1).
  - Latency is 1 cycle from input transfer to out_valid. Full throughput is 1 word/cycle when out_ready stays high.
- Output holding: while out_valid && !out_ready, s_word and out_last hold stable and in_ready is 0. out_valid drops after a transfer unless a new word is loaded in the same cycle (simultaneous in/out transfer is legal).
- When the out_last word transfers, the state goes to DONE and carry_out <= c.
- DONE: done=1 for exactly one cycle, busy falls in the same cycle, and the next state is IDLE. carry_out holds until the next accepted start. A start coinciding with done is ignored; it is sampled only in IDLE.
- NUM_WORDS=1: a single transfer has out_last=1 on its output.
- in_valid while not in RUN, or after cnt reaches NUM_WORDS: ignored (in_ready=0).

Decomposition:
- parameter.v (shared `include): DATA_WIDTH and the FSM state encodings (IDLE, RUN, DONE, 2 bits).
- One sub-module: mul_add_cell. It is a combinational word x*y+z+cin with outputs s and cout of DATA_WIDTH each, and is instantiated once.
- The FSM, counter, carry register and output holding register stay in mul_add_row.

Test Plan (DATA_WIDTH=8, NUM_WORDS=4 unless stated):
- Max operands: b=0xFF, cin=0xFF, A=Z={FF,FF,FF,FF}, out_ready=1 -> s_word FF,FF,FF,FF on 4 consecutive cycles; out_last on the 4th; carry_out=0xFF; done 1 cycle after.
- Carry propagation: b=0x02, cin=0, A={80,01,00,00}, Z=0 -> s_word 00,03,00,00; carry_out=0x00; separately A={00,00,00,80} -> last s_word 00, carry_out=0x01.
- Backpressure: out_ready low for 3 cycles after first out_valid -> in_ready=0, s_word stable for those 3 cycles, no word lost or duplicated, final results identical to the unstalled run.
- Start while busy: second start pulse mid-row with b=0x55 -> ignored; results use the original b; busy stays high until done.
- Reset mid-row: rst_n low after 2 words transferred -> all outputs 0 immediately (asynchronous); new start with b=1, cin=0, A={01,02,03,04}, Z={10,20,30,40} -> s_word 11,22,33,44, carry_out 0.
- NUM_WORDS=1 build: b=0x10, cin=0x05, a=0x10, z=0x00 -> s_word=0x05, out_last=1, carry_out=0x01, done pulse.

Source files
------------

// File: rtl/mul_add_row_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mul_add_row_pkg                                                  |
// | Shared widths and FSM encoding for the mul_add_row slice.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mul_add_row_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_WORDS  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_add_row_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mul_add_row_if                                                   |
// | Control, operand stream and result stream of one row engine.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface mul_add_row_if
  import mul_add_row_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic                  start;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] cin;
  logic                  busy;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a_word;
  logic [DATA_WIDTH-1:0] z_word;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] s_word;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] carry_out;
  logic                  done;

  modport master (
    output start, b, cin, in_valid, a_word, z_word, out_ready,
    input  busy, in_ready, out_valid, s_word, out_last, carry_out, done
  );

  modport slave (
    input  start, b, cin, in_valid, a_word, z_word, out_ready,
    output busy, in_ready, out_valid, s_word, out_last, carry_out, done
  );
endinterface
`default_nettype wire

// File: rtl/mul_add_row_cell.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mul_add_cell                                                     |
// | Combinational word multiply-add: {cout, s} = x*y + z + cin.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mul_add_cell
  import mul_add_row_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  wire logic [DATA_WIDTH-1:0] x,
  input  wire logic [DATA_WIDTH-1:0] y,
  input  wire logic [DATA_WIDTH-1:0] z,
  input  wire logic [DATA_WIDTH-1:0] cin,
  output      logic [DATA_WIDTH-1:0] s,
  output      logic [DATA_WIDTH-1:0] cout
);
  localparam logic [DATA_WIDTH-1:0] c_zero = '0;

  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [2*DATA_WIDTH-1:0] w_sum;

  // (2^W-1)^2 + 2(2^W-1) = 2^(2W)-1, so the double-width sum never wraps
  assign w_prod      = {c_zero, x} * {c_zero, y};
  assign w_sum       = w_prod + {c_zero, z} + {c_zero, cin};
  assign {cout, s}   = w_sum;
endmodule
`default_nettype wire

// File: rtl/mul_add_row.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mul_add_row                                                      |
// | Word-serial {carry_out, S} = A*b + Z + cin with valid/ready I/O. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mul_add_row
  import mul_add_row_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_WORDS  = DEFAULT_NUM_WORDS,
  parameter int CNT_WIDTH  = $clog2(NUM_WORDS + 1)
) (
  input wire logic clk,
  input wire logic rst_n,
  mul_add_row_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] c_num_words = CNT_WIDTH'(NUM_WORDS);
  localparam logic [CNT_WIDTH-1:0] c_last_idx  = CNT_WIDTH'(NUM_WORDS - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_c;
  logic [DATA_WIDTH-1:0] r_s;
  logic [DATA_WIDTH-1:0] r_carry_out;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [DATA_WIDTH-1:0] w_s;
  logic [DATA_WIDTH-1:0] w_cout;
  logic                  w_in_ready;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_start_acc;

  mul_add_cell #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cell (
    .x    (bus.a_word),
    .y    (r_b),
    .z    (bus.z_word),
    .cin  (r_c),
    .s    (w_s),
    .cout (w_cout)
  );

  // A held output blocks new input, so nothing is overwritten under backpressure
  assign w_in_ready  = (r_state == ST_RUN) && (r_cnt < c_num_words) &&
                       (!r_out_valid || bus.out_ready);
  assign w_in_xfer   = bus.in_valid && w_in_ready;
  assign w_out_xfer  = r_out_valid && bus.out_ready;
  assign w_start_acc = (r_state == ST_IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_next = ST_RUN;
      ST_RUN:  if (w_out_xfer && r_out_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b         <= '0;
      r_c         <= '0;
      r_s         <= '0;
      r_carry_out <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_b   <= bus.b;
        r_c   <= bus.cin;
        r_cnt <= '0;
      end
      if (w_in_xfer) begin
        r_s         <= w_s;
        r_c         <= w_cout;
        r_cnt       <= r_cnt + 1'b1;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_cnt == c_last_idx);
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      // The carry register is final once the last word has been loaded
      if (w_out_xfer && r_out_last) begin
        r_carry_out <= r_c;
      end
    end
  end

  assign bus.busy      = (r_state == ST_RUN);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.s_word    = r_s;
  assign bus.out_last  = r_out_last;
  assign bus.carry_out = r_carry_out;
endmodule
`default_nettype wire

// File: tb/tb_mul_add_row.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mul_add_row                                                   |
// | Scoreboard bench for mul_add_row (8-bit words, 4-word and 1-word).|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mul_add_row;
  localparam int DW = 8;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_add_row_if #(.DATA_WIDTH(DW)) bus ();
  mul_add_row_if #(.DATA_WIDTH(DW)) bus1 ();

  mul_add_row #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mul_add_row #(.DATA_WIDTH(DW), .NUM_WORDS(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW:0]   sb_q[$];
  logic [DW-1:0] m_b;
  logic [DW-1:0] m_c;
  int            stall_left = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // out_ready is low for stall_left cycles once a result is showing
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && bus.out_valid) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst_n && bus.out_valid) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        if (bus.out_ready) begin
          e = sb_q.pop_front();
          check("s_word", 32'(bus.s_word), 32'(e[DW-1:0]));
          check("out_last", 32'(bus.out_last), 32'(e[DW]));
        end else begin
          e = sb_q[0];
          check("stall_hold", 32'(bus.s_word), 32'(e[DW-1:0]));
          check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
      end
    end
  end

  task automatic do_start(input logic [DW-1:0] b, input logic [DW-1:0] cin);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.b     = b;
    bus.cin   = cin;
    m_b       = b;
    m_c       = cin;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  // Entered and left at posedge+1 so back-to-back calls give full throughput
  task automatic drive_word(input logic [DW-1:0] a, input logic [DW-1:0] z, input logic last);
    logic [2*DW-1:0] t;
    bus.in_valid = 1'b1;
    bus.a_word   = a;
    bus.z_word   = z;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      @(posedge clk); #1;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) begin
      t = {{DW{1'b0}}, a} * {{DW{1'b0}}, m_b} + {{DW{1'b0}}, z} + {{DW{1'b0}}, m_c};
      sb_q.push_back({last, t[DW-1:0]});
      m_c = t[2*DW-1:DW];
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    check("done_seen", 32'(bus.done), 32'd1);
    check("carry_out", 32'(bus.carry_out), 32'(m_c));
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("carry_hold", 32'(bus.carry_out), 32'(m_c));
    @(posedge clk); #1;
  endtask

  task automatic run_row(input logic [DW-1:0] b, input logic [DW-1:0] cin,
                         input logic [DW-1:0] a[NW], input logic [DW-1:0] z[NW]);
    do_start(b, cin);
    for (int i = 0; i < NW; i++) drive_word(a[i], z[i], i == NW - 1);
    wait_done();
  endtask

  initial begin
    logic [DW-1:0] av[NW];
    logic [DW-1:0] zv[NW];
    int k1;

    rst_n = 1'b0;
    {bus.start, bus.b, bus.cin, bus.in_valid, bus.a_word, bus.z_word} = '0;
    {bus1.start, bus1.b, bus1.cin, bus1.in_valid, bus1.a_word, bus1.z_word} = '0;
    bus1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_s_word", 32'(bus.s_word), 32'd0);
    check("rst_carry_out", 32'(bus.carry_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    bus.in_valid = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    av = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; zv = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_row(8'hFF, 8'hFF, av, zv);
    check("max_carry_const", 32'(bus.carry_out), 32'hFF);

    av = '{8'h80, 8'h01, 8'h00, 8'h00}; zv = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_row(8'h02, 8'h00, av, zv);
    check("prop_carry0", 32'(bus.carry_out), 32'h00);

    av = '{8'h00, 8'h00, 8'h00, 8'h80};
    run_row(8'h02, 8'h00, av, zv);
    check("prop_carry1", 32'(bus.carry_out), 32'h01);

    av = '{8'h12, 8'h34, 8'h56, 8'h78}; zv = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_row(8'hA7, 8'h3C, av, zv);
    stall_left = 3;
    run_row(8'hA7, 8'h3C, av, zv);

    // Second start mid-row must not disturb the latched multiplier
    do_start(8'h03, 8'h01);
    av = '{8'hC8, 8'hE1, 8'h7F, 8'hFE}; zv = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_word(av[0], zv[0], 1'b0);
    drive_word(av[1], zv[1], 1'b0);
    bus.start = 1'b1;
    bus.b     = 8'h55;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_mid_start", 32'(bus.busy), 32'd1);
    drive_word(av[2], zv[2], 1'b0);
    drive_word(av[3], zv[3], 1'b1);
    wait_done();

    do_start(8'h07, 8'h00);
    drive_word(8'hAA, 8'h01, 1'b0);
    drive_word(8'hBB, 8'h02, 1'b0);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check("arst_s_word", 32'(bus.s_word), 32'd0);
    check("arst_carry_out", 32'(bus.carry_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    av = '{8'h01, 8'h02, 8'h03, 8'h04}; zv = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_row(8'h01, 8'h00, av, zv);
    check("post_rst_carry", 32'(bus.carry_out), 32'h00);

    // Single-word build
    @(posedge clk); #1;
    bus1.start = 1'b1; bus1.b = 8'h10; bus1.cin = 8'h05;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    check("n1_busy", 32'(bus1.busy), 32'd1);
    bus1.a_word = 8'h10; bus1.z_word = 8'h00; bus1.in_valid = 1'b1;
    @(negedge clk);
    check("n1_in_ready", 32'(bus1.in_ready), 32'd1);
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("n1_out_valid", 32'(bus1.out_valid), 32'd1);
    check("n1_s_word", 32'(bus1.s_word), 32'h05);
    check("n1_out_last", 32'(bus1.out_last), 32'd1);
    k1 = 0;
    while (!bus1.done && k1 < 20) begin
      @(negedge clk);
      k1++;
    end
    check("n1_done", 32'(bus1.done), 32'd1);
    check("n1_carry_out", 32'(bus1.carry_out), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
